// File: rtl/toggle_rx_pkg.sv
// Shared types and default sizing for the toggle-event receiver.
package toggle_rx_pkg;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_PEND_W      = 4;

    // Receiver states; EMPTY/HAVE/FULL track the pending-event count.
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_EMPTY = 2'd1,
        ST_HAVE  = 2'd2,
        ST_FULL  = 2'd3
    } state_t;

endpackage

// File: rtl/toggle_sync.sv
// Multi-flop synchroniser for the asynchronous toggle line.
module toggle_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Shift the raw level one stage deeper each cycle.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    // Synchroniser flops; cleared by the asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '0;
        else      sync_q <= sync_d;
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/toggle_event_rx.sv
// Receive side of a toggle-encoded event link: each level change on t_in
// becomes one event, strobed on ev_pulse, counted on ev_count and queued
// as a pending count drained by the consumer.
// Optional build macro TOGGLE_RX_FILTER_EN: a synchronised level is only
// accepted once it has been stable for two cycles (one extra cycle of
// latency, one-cycle excursions ignored, INIT one cycle longer).
//
// Handshake: ev_valid is a registered decode of the state (HAVE or FULL).
// One event is consumed on every rising edge where ev_valid && ev_ready;
// ev_ready while ev_valid is low is ignored, and there is no combinational
// path from ev_ready to any output.
module toggle_event_rx
    import toggle_rx_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int PEND_W      = DEF_PEND_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              t_in,
    output logic              ev_pulse,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [CNT_W-1:0]  ev_count,
    output logic [PEND_W-1:0] pend,
    output logic              overflow,
    input  logic              clr_ovf,
    output state_t            dbg_state
);

`ifdef TOGGLE_RX_FILTER_EN
    localparam int INIT_LEN = SYNC_STAGES + 2;
`else
    localparam int INIT_LEN = SYNC_STAGES + 1;
`endif
    localparam int                INIT_W   = $clog2(INIT_LEN + 1);
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    logic sync_out;

    toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (t_in),
        .q   (sync_out)
    );

    state_t              state_q, state_d;
    logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
    logic                last_q, last_d;
    logic                pulse_q, pulse_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PEND_W-1:0]   pend_q, pend_d;
    logic                ovf_q, ovf_d;
    logic                level;
    logic                event_det;
    logic                pop;

`ifdef TOGGLE_RX_FILTER_EN
    logic prev_q, prev_d;

    // Remember last cycle's synchronised level for the stability test.
    always_comb begin
        prev_d = sync_out;
    end

    // A new level counts only when it matches the previous sample.
    always_comb begin
        level = (sync_out == prev_q) ? sync_out : last_q;
    end

    // Stability-history flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) prev_q <= 1'b0;
        else      prev_q <= prev_d;
    end
`else
    // Without the filter the synchronised level is used directly.
    always_comb begin
        level = sync_out;
    end
`endif

    // Next-state, event detection, counters and overflow.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        last_d     = level;
        pulse_d    = 1'b0;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        ovf_d      = clr_ovf ? 1'b0 : ovf_q;
        event_det  = 1'b0;
        pop        = ((state_q == ST_HAVE) || (state_q == ST_FULL)) && ev_ready;

        if (state_q == ST_INIT) begin
            // Track the line silently until the synchroniser has settled.
            last_d = sync_out;
            if (init_cnt_q == INIT_W'(INIT_LEN - 1)) state_d = ST_EMPTY;
            else                                     init_cnt_d = init_cnt_q + INIT_W'(1);
        end else begin
            event_det = level ^ last_q;
            pulse_d   = event_det;
            if (event_det) cnt_d = cnt_q + CNT_W'(1);

            case (state_q)
                ST_EMPTY: begin
                    if (event_det) pend_d = PEND_W'(1);
                end
                ST_HAVE: begin
                    if (event_det && !pop)      pend_d = pend_q + PEND_W'(1);
                    else if (pop && !event_det) pend_d = pend_q - PEND_W'(1);
                end
                ST_FULL: begin
                    // Saturated: a further event is lost and flagged.
                    if (event_det && !pop)      ovf_d  = 1'b1;
                    else if (pop && !event_det) pend_d = pend_q - PEND_W'(1);
                end
                default: ;
            endcase

            if (pend_d == '0)            state_d = ST_EMPTY;
            else if (pend_d == PEND_MAX) state_d = ST_FULL;
            else                         state_d = ST_HAVE;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            last_q     <= 1'b0;
            pulse_q    <= 1'b0;
            cnt_q      <= '0;
            pend_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            last_q     <= last_d;
            pulse_q    <= pulse_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
        end
    end

    assign ev_pulse  = pulse_q;
    assign ev_valid  = (state_q == ST_HAVE) || (state_q == ST_FULL);
    assign ev_count  = cnt_q;
    assign pend      = pend_q;
    assign overflow  = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_toggle_event_rx.sv
// Bench for toggle_event_rx: directed scenarios followed by random traffic,
// all checked against a sample-history reference model.
`timescale 1ns/1ps
module tb_toggle_event_rx;
    import toggle_rx_pkg::*;

    localparam int S      = 2;
    localparam int CNT_W  = 8;
    localparam int PEND_W = 4;
    localparam int PMAX   = (1 << PEND_W) - 1;
`ifdef TOGGLE_RX_FILTER_EN
    localparam int INIT_LEN = S + 2;
    localparam int LAT      = S + 1;
`else
    localparam int INIT_LEN = S + 1;
    localparam int LAT      = S;
`endif

    // Clock and reset.
    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic t_in     = 1'b0;
    logic ev_ready = 1'b0;
    logic clr_ovf  = 1'b0;
    logic              ev_pulse;
    logic              ev_valid;
    logic [CNT_W-1:0]  ev_count;
    logic [PEND_W-1:0] pend;
    logic              overflow;
    state_t            dbg_state;

    always #5 clk = ~clk;

    toggle_event_rx #(.SYNC_STAGES(S), .CNT_W(CNT_W), .PEND_W(PEND_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .t_in      (t_in),
        .ev_pulse  (ev_pulse),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_count  (ev_count),
        .pend      (pend),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf),
        .dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: hist[j-1] holds t_in as sampled on the j-th edge
    // after reset release; the synchronised view is that history delayed.
    int   k;
    logic hist[$];
    int   pend_m;
    int   cnt_m;
    logic ovf_m;
    logic exp_pulse;
    int   pulses_seen;
`ifdef TOGGLE_RX_FILTER_EN
    logic acc_m;
`endif
    logic [CNT_W-1:0] exp_q[$];

    function automatic logic lvl(input int j);
        if (j <= 0) return 1'b0;
        return hist[j-1];
    endfunction

    task automatic model_reset();
        check("sb_drained", exp_q.size(), 0);
        exp_q.delete();
        hist.delete();
        k         = 0;
        pend_m    = 0;
        cnt_m     = 0;
        ovf_m     = 1'b0;
        exp_pulse = 1'b0;
`ifdef TOGGLE_RX_FILTER_EN
        acc_m = 1'b0;
`endif
    endtask

    task automatic model_edge(input logic t, input logic rdy, input logic clr);
        logic s, p, ev, pop, ovf_set;
        k++;
        hist.push_back(t);
        s       = lvl(k - S);
        p       = lvl(k - S - 1);
        pop     = (pend_m > 0) && rdy;
        ev      = 1'b0;
        ovf_set = 1'b0;
`ifdef TOGGLE_RX_FILTER_EN
        if (k <= INIT_LEN) begin
            acc_m = s;
        end else if ((s == p) && (s != acc_m)) begin
            ev    = 1'b1;
            acc_m = s;
        end
`else
        ev = (k > INIT_LEN) && (s != p);
`endif
        if (ev) begin
            cnt_m = (cnt_m + 1) % (1 << CNT_W);
            exp_q.push_back(CNT_W'(cnt_m));
        end
        if (ev && !pop) begin
            if (pend_m == PMAX) ovf_set = 1'b1;
            else                pend_m++;
        end else if (pop && !ev) begin
            pend_m--;
        end
        if (ovf_set)  ovf_m = 1'b1;
        else if (clr) ovf_m = 1'b0;
        exp_pulse = ev;
    endtask

    task automatic compare_outputs();
        check("ev_pulse", ev_pulse, exp_pulse);
        check("pend", pend, pend_m);
        check("ev_valid", ev_valid, pend_m > 0);
        check("ev_count", ev_count, cnt_m);
        check("overflow", overflow, ovf_m);
        if (ev_pulse === 1'b1) begin
            pulses_seen++;
            check("sb_has_entry", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("sb_count", ev_count, exp_q.pop_front());
        end
    endtask

    // Driver: one clock, model advanced with the inputs the DUT sampled.
    task automatic step();
        @(posedge clk);
        model_edge(t_in, ev_ready, clr_ovf);
        #1;
        compare_outputs();
    endtask

    task automatic apply_reset(input logic t_level, input int cycles);
        t_in     = t_level;
        ev_ready = 1'b0;
        clr_ovf  = 1'b0;
        rst      = 1'b0;
        #1;
        check("rst_pulse", ev_pulse, 0);
        check("rst_valid", ev_valid, 0);
        check("rst_count", ev_count, 0);
        check("rst_pend", pend, 0);
        check("rst_ovf", overflow, 0);
        check("rst_state", 32'(dbg_state), 32'(ST_INIT));
        model_reset();
        repeat (cycles) @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        pulses_seen = 0;
        #2;

        // Line held high through reset: no spurious event.
        apply_reset(1'b1, 3);
        p0 = pulses_seen;
        repeat (10) step();
        check("t1_no_pulse", pulses_seen - p0, 0);
        check("t1_pend", pend, 0);
        check("t1_state", 32'(dbg_state), 32'(ST_EMPTY));

        // Single toggle, consumer not ready.
        t_in = ~t_in;
        repeat (6) step();
        check("t2_pend", pend, 1);
        check("t2_valid", ev_valid, 1);
        check("t2_count", ev_count, 1);
        ev_ready = 1'b1;
        step();
        ev_ready = 1'b0;
        step();

        // Three spaced toggles, then drain.
        repeat (3) begin
            t_in = ~t_in;
            repeat (4) step();
        end
        check("t3_pend", pend, 3);
        ev_ready = 1'b1;
        repeat (5) step();
        ev_ready = 1'b0;
        check("t3_pend_drained", pend, 0);
        check("t3_valid", ev_valid, 0);
        check("t3_count", ev_count, 4);

        // Saturation and overflow.
        apply_reset(1'b0, 2);
        repeat (INIT_LEN + 2) step();
        repeat (17) begin
            t_in = ~t_in;
            repeat (3) step();
        end
        check("t4_pend", pend, PMAX);
        check("t4_state", 32'(dbg_state), 32'(ST_FULL));
        check("t4_ovf", overflow, 1);
        check("t4_count", ev_count, 17);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("t4_ovf_clr", overflow, 0);

        // Event and pop on the same edge while full.
        t_in = ~t_in;
        repeat (LAT) step();
        ev_ready = 1'b1;
        step();
        ev_ready = 1'b0;
        step();
        check("t5_full_pend", pend, PMAX);
        check("t5_full_ovf", overflow, 0);

        // Event and pop on the same edge with two pending.
        ev_ready = 1'b1;
        repeat (PMAX - 2) step();
        ev_ready = 1'b0;
        check("t5_pend2_before", pend, 2);
        t_in = ~t_in;
        repeat (LAT) step();
        ev_ready = 1'b1;
        step();
        ev_ready = 1'b0;
        step();
        check("t5_pend2_after", pend, 2);

        // Reset mid-operation with five pending.
        repeat (3) begin
            t_in = ~t_in;
            repeat (3) step();
        end
        check("t6_pend5", pend, 5);
        apply_reset(t_in, 2);
        repeat (INIT_LEN + 2) step();

        // One-cycle excursion on the line.
        p0 = pulses_seen;
        t_in = ~t_in;
        step();
        t_in = ~t_in;
        repeat (6) step();
`ifdef TOGGLE_RX_FILTER_EN
        check("t6_glitch", pulses_seen - p0, 0);
`else
        check("t6_glitch", pulses_seen - p0, 2);
`endif

        // Random traffic.
        repeat (600) begin
            if ($urandom_range(0, 2) == 0) t_in = ~t_in;
            ev_ready = ($urandom_range(0, 3) == 0);
            clr_ovf  = ($urandom_range(0, 19) == 0);
            step();
        end
        ev_ready = 1'b0;
        clr_ovf  = 1'b0;
        repeat (8) step();
        check("sb_final", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
